stack_ctrl: RTL and testbench

Sequencer for the CPU's 2-read/1-write data stack RAM (async read, sync write). Owns the stack pointer and depth counter, drives both read addresses so that top-of-stack and next-of-stack are always visible, and turns one-per-cycle stack operations from the decode stage into RAM writes. SWAP uses two RAM writes over two cycles, so the block has a valid/ready handshake toward decode.

---
 rtl/stack_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_stack_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Stack sequencer for a 2-read/1-write data stack RAM: owns sp/depth, drives TOS/NOS read addresses,
// turns decode-stage stack ops into RAM writes. Define STACK_CTRL_GUARD_EN to enable depth guarding and error flags.
module stack_ctrl #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [15:0]      op_data,
    output logic [15:0]      top,
    output logic [15:0]      next,
    output logic [WIDTH:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             err_clear,
    output logic [WIDTH-1:0] mem_dout_addr0,
    output logic [WIDTH-1:0] mem_dout_addr1,
    input  logic [15:0]      mem_dout0,
    input  logic [15:0]      mem_dout1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);

    typedef enum logic {IDLE, SWAP2} state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_BINOP   = 3'd4;
    localparam logic [2:0] OP_DUP     = 3'd5;
    localparam logic [2:0] OP_SWAP    = 3'd6;
    localparam logic [2:0] OP_OVER    = 3'd7;

    localparam logic [WIDTH:0] DEPTH_MAX = (WIDTH+1)'(SIZE);
    localparam logic [WIDTH:0] DEPTH_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] DEPTH_TWO = (WIDTH+1)'(2);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sp_reg, sp_next;
    logic [WIDTH:0]   depth_reg, depth_next;
    logic [15:0]      hold_reg, hold_next;

    logic [WIDTH-1:0] sp_m1, sp_m2;
    logic [WIDTH:0]   depth_inc, depth_dec;
    logic             accept, ovf, unf, viol;

    assign sp_m1 = sp_reg - WIDTH'(1);
    assign sp_m2 = sp_reg - WIDTH'(2);
    // depth wraps modulo SIZE+1; with the guard enabled the wrap is never reached
    assign depth_inc = (depth_reg == DEPTH_MAX) ? '0 : depth_reg + DEPTH_ONE;
    assign depth_dec = (depth_reg == '0) ? DEPTH_MAX : depth_reg - DEPTH_ONE;

    assign accept = op_valid && (state_reg == IDLE);

    always_comb begin
        ovf = 1'b0;
        unf = 1'b0;
        case (op)
            OP_PUSH:              ovf = (depth_reg == DEPTH_MAX);
            OP_DUP: begin
                ovf = (depth_reg == DEPTH_MAX);
                unf = (depth_reg < DEPTH_ONE);
            end
            OP_OVER: begin
                ovf = (depth_reg == DEPTH_MAX);
                unf = (depth_reg < DEPTH_TWO);
            end
            OP_POP, OP_REPLACE:   unf = (depth_reg < DEPTH_ONE);
            OP_BINOP, OP_SWAP:    unf = (depth_reg < DEPTH_TWO);
            default: ;
        endcase
    end

`ifdef STACK_CTRL_GUARD_EN
    logic err_overflow_reg, err_underflow_reg;

    assign viol = ovf || unf;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow_reg  <= 1'b0;
            err_underflow_reg <= 1'b0;
        end else begin
            // a new error in the same cycle as err_clear wins
            err_overflow_reg  <= (err_overflow_reg && !err_clear) || (accept && ovf);
            err_underflow_reg <= (err_underflow_reg && !err_clear) || (accept && unf);
        end
    end

    assign err_overflow  = err_overflow_reg;
    assign err_underflow = err_underflow_reg;
`else
    logic unused_guard;

    assign viol          = 1'b0;
    assign unused_guard  = err_clear ^ ovf ^ unf;
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        sp_next      = sp_reg;
        depth_next   = depth_reg;
        hold_next    = hold_reg;
        mem_we       = 1'b0;
        mem_din_addr = sp_reg;
        mem_din      = op_data;
        if (state_reg == SWAP2) begin
            mem_we       = 1'b1;
            mem_din_addr = sp_m2;
            mem_din      = hold_reg;
            state_next   = IDLE;
        end else if (accept && !viol) begin
            case (op)
                OP_PUSH: begin
                    mem_we     = 1'b1;
                    sp_next    = sp_reg + WIDTH'(1);
                    depth_next = depth_inc;
                end
                OP_POP: begin
                    sp_next    = sp_m1;
                    depth_next = depth_dec;
                end
                OP_REPLACE: begin
                    mem_we       = 1'b1;
                    mem_din_addr = sp_m1;
                end
                OP_BINOP: begin
                    mem_we       = 1'b1;
                    mem_din_addr = sp_m2;
                    sp_next      = sp_m1;
                    depth_next   = depth_dec;
                end
                OP_DUP, OP_OVER: begin
                    mem_we     = 1'b1;
                    mem_din    = (op == OP_DUP) ? mem_dout0 : mem_dout1;
                    sp_next    = sp_reg + WIDTH'(1);
                    depth_next = depth_inc;
                end
                OP_SWAP: begin
                    mem_we       = 1'b1;
                    mem_din_addr = sp_m1;
                    mem_din      = mem_dout1;
                    hold_next    = mem_dout0;
                    state_next   = SWAP2;
                end
                default: ;
            endcase
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sp_reg    <= '0;
            depth_reg <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            depth_reg <= depth_next;
            hold_reg  <= hold_next;
        end
    end

    assign op_ready       = (state_reg == IDLE);
    assign mem_dout_addr0 = sp_m1;
    assign mem_dout_addr1 = sp_m2;
    assign top            = mem_dout0;
    assign next           = mem_dout1;
    assign depth          = depth_reg;
    assign empty          = (depth_reg == '0);
    assign full           = (depth_reg == DEPTH_MAX);

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural 2R/1W RAM attached.
module tb_stack_ctrl;

    localparam int WIDTH = 6;
    localparam int SIZE  = 64;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3;
    localparam logic [2:0] BINOP = 3'd4, DUP = 3'd5, SWAP = 3'd6, OVER = 3'd7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op = 3'd0;
    logic [15:0]      op_data = 16'h0;
    logic [15:0]      top, next;
    logic [WIDTH:0]   depth;
    logic             empty, full, err_overflow, err_underflow;
    logic             err_clear = 1'b0;
    logic [WIDTH-1:0] mem_dout_addr0, mem_dout_addr1, mem_din_addr;
    logic [15:0]      mem_dout0, mem_dout1, mem_din;
    logic             mem_we;

    logic [15:0]      ram [0:SIZE-1];

    int total = 0;
    int bad   = 0;

    logic             we_s, rdy_s;
    logic [WIDTH-1:0] addr_s;
    logic [15:0]      din_s;

    always #5 clk = ~clk;

    stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .op_data(op_data), .top(top), .next(next), .depth(depth),
        .empty(empty), .full(full), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .err_clear(err_clear),
        .mem_dout_addr0(mem_dout_addr0), .mem_dout_addr1(mem_dout_addr1),
        .mem_dout0(mem_dout0), .mem_dout1(mem_dout1), .mem_we(mem_we),
        .mem_din_addr(mem_din_addr), .mem_din(mem_din)
    );

    assign mem_dout0 = ram[mem_dout_addr0];
    assign mem_dout1 = ram[mem_dout_addr1];
    always @(posedge clk) if (mem_we) ram[mem_din_addr] <= mem_din;

    // Presents one op for one cycle, captures the write-port outputs of the acceptance cycle.
    task automatic do_op(input logic [2:0] o, input logic [15:0] d);
        @(negedge clk);
        op_valid = 1'b1; op = o; op_data = d;
        #1;
        we_s = mem_we; addr_s = mem_din_addr; din_s = mem_din; rdy_s = op_ready;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP; op_data = 16'h0;
        $display("op=%0d data=%h we=%b addr=%0d din=%h depth=%0d", o, d, we_s, addr_s, din_s, depth);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; op_valid = 1'b1; op = PUSH; op_data = 16'hdead;
        #1;
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        @(posedge clk); @(negedge clk);
        reset = 1'b0; op_valid = 1'b0; op = NOP; op_data = 16'h0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (depth !== 7'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
        total++;
        if ({empty, full, op_ready} !== 3'b101) begin bad++; $display("FAIL reset_flags got=%b want=101", {empty, full, op_ready}); end
        total++;
        if ({err_overflow, err_underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", {err_overflow, err_underflow}); end
        total++;
        if (mem_dout_addr0 !== 6'd63 || mem_dout_addr1 !== 6'd62) begin
            bad++; $display("FAIL reset_addr got=%0d/%0d want=63/62", mem_dout_addr0, mem_dout_addr1);
        end
    endtask

    task automatic test_push();
        do_op(PUSH, 16'h1111);
        total++;
        if ({we_s, addr_s, din_s} !== {1'b1, 6'd0, 16'h1111}) begin bad++; $display("FAIL push1_write got=%b/%0d/%h want=1/0/1111", we_s, addr_s, din_s); end
        do_op(PUSH, 16'h2222);
        total++;
        if ({we_s, addr_s} !== {1'b1, 6'd1}) begin bad++; $display("FAIL push2_write got=%b/%0d want=1/1", we_s, addr_s); end
        total++;
        if (top !== 16'h2222 || next !== 16'h1111 || depth !== 7'd2) begin
            bad++; $display("FAIL push_stack got=%h/%h/%0d want=2222/1111/2", top, next, depth);
        end
    endtask

    task automatic test_swap();
        do_op(SWAP, 16'h0);
        total++;
        if ({we_s, addr_s, din_s} !== {1'b1, 6'd1, 16'h1111}) begin bad++; $display("FAIL swap1_write got=%b/%0d/%h want=1/1/1111", we_s, addr_s, din_s); end
        // SWAP2 cycle: hold a PUSH on the port, it must not be taken yet
        op_valid = 1'b1; op = PUSH; op_data = 16'h4444;
        #1;
        total++;
        if (op_ready !== 1'b0) begin bad++; $display("FAIL swap2_ready got=%b want=0", op_ready); end
        total++;
        if ({mem_we, mem_din_addr, mem_din} !== {1'b1, 6'd0, 16'h2222}) begin bad++; $display("FAIL swap2_write got=%b/%0d/%h want=1/0/2222", mem_we, mem_din_addr, mem_din); end
        @(posedge clk); #1;
        total++;
        if (op_ready !== 1'b1 || depth !== 7'd2) begin bad++; $display("FAIL swap_done got=%b/%0d want=1/2", op_ready, depth); end
        total++;
        if (top !== 16'h1111 || next !== 16'h2222) begin bad++; $display("FAIL swap_stack got=%h/%h want=1111/2222", top, next); end
        total++;
        if ({mem_we, mem_din_addr, mem_din} !== {1'b1, 6'd2, 16'h4444}) begin bad++; $display("FAIL held_push_write got=%b/%0d/%h want=1/2/4444", mem_we, mem_din_addr, mem_din); end
        @(posedge clk); #1;
        op_valid = 1'b0; op = NOP; op_data = 16'h0;
        total++;
        if (depth !== 7'd3 || top !== 16'h4444) begin bad++; $display("FAIL held_push got=%0d/%h want=3/4444", depth, top); end
        do_op(POP, 16'h0);
        total++;
        if (we_s !== 1'b0 || depth !== 7'd2 || top !== 16'h1111) begin bad++; $display("FAIL pop got=%b/%0d/%h want=0/2/1111", we_s, depth, top); end
    endtask

    task automatic test_binop_dup();
        do_op(BINOP, 16'h3333);
        total++;
        if ({we_s, addr_s} !== {1'b1, 6'd0}) begin bad++; $display("FAIL binop_write got=%b/%0d want=1/0", we_s, addr_s); end
        total++;
        if (depth !== 7'd1 || top !== 16'h3333) begin bad++; $display("FAIL binop got=%0d/%h want=1/3333", depth, top); end
        do_op(DUP, 16'h0);
        total++;
        if ({we_s, addr_s, din_s} !== {1'b1, 6'd1, 16'h3333}) begin bad++; $display("FAIL dup_write got=%b/%0d/%h want=1/1/3333", we_s, addr_s, din_s); end
        total++;
        if (depth !== 7'd2 || top !== 16'h3333 || next !== 16'h3333) begin bad++; $display("FAIL dup got=%0d/%h/%h want=2/3333/3333", depth, top, next); end
    endtask

    task automatic test_replace_over_nop();
        do_op(REPLACE, 16'h5555);
        total++;
        if ({we_s, addr_s} !== {1'b1, 6'd1} || depth !== 7'd2 || top !== 16'h5555 || next !== 16'h3333) begin
            bad++; $display("FAIL replace got=%b/%0d/%0d/%h/%h want=1/1/2/5555/3333", we_s, addr_s, depth, top, next);
        end
        do_op(OVER, 16'h0);
        total++;
        if ({we_s, addr_s, din_s} !== {1'b1, 6'd2, 16'h3333}) begin bad++; $display("FAIL over_write got=%b/%0d/%h want=1/2/3333", we_s, addr_s, din_s); end
        total++;
        if (depth !== 7'd3 || top !== 16'h3333 || next !== 16'h5555) begin bad++; $display("FAIL over got=%0d/%h/%h want=3/3333/5555", depth, top, next); end
        do_op(NOP, 16'h7777);
        total++;
        if (we_s !== 1'b0 || depth !== 7'd3 || rdy_s !== 1'b1) begin bad++; $display("FAIL nop got=%b/%0d/%b want=0/3/1", we_s, depth, rdy_s); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < SIZE; i++) do_op(PUSH, 16'(i + 16'h100));
        total++;
        if (full !== 1'b1 || depth !== 7'd64 || empty !== 1'b0) begin bad++; $display("FAIL full got=%b/%0d/%b want=1/64/0", full, depth, empty); end
        do_op(PUSH, 16'hbeef);
`ifdef STACK_CTRL_GUARD_EN
        total++;
        if (we_s !== 1'b0 || err_overflow !== 1'b1 || depth !== 7'd64) begin bad++; $display("FAIL overflow got=%b/%b/%0d want=0/1/64", we_s, err_overflow, depth); end
        total++;
        if (top !== 16'h013f) begin bad++; $display("FAIL overflow_top got=%h want=013f", top); end
        @(negedge clk); err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        total++;
        if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", err_overflow); end
`else
        total++;
        if ({we_s, addr_s} !== {1'b1, 6'd0} || depth !== 7'd0 || empty !== 1'b1) begin bad++; $display("FAIL wrap_push got=%b/%0d/%0d/%b want=1/0/0/1", we_s, addr_s, depth, empty); end
        total++;
        if ({err_overflow, err_underflow} !== 2'b00) begin bad++; $display("FAIL wrap_err got=%b want=00", {err_overflow, err_underflow}); end
`endif
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(POP, 16'h0);
`ifdef STACK_CTRL_GUARD_EN
        total++;
        if (err_underflow !== 1'b1 || err_overflow !== 1'b0 || depth !== 7'd0 || mem_dout_addr0 !== 6'd63) begin
            bad++; $display("FAIL pop_underflow got=%b/%b/%0d/%0d want=1/0/0/63", err_underflow, err_overflow, depth, mem_dout_addr0);
        end
        @(negedge clk); err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b want=0", err_underflow); end
        err_clear = 1'b1;
        do_op(DUP, 16'h0);
        err_clear = 1'b0;
        total++;
        if (we_s !== 1'b0 || err_underflow !== 1'b1 || err_overflow !== 1'b0 || depth !== 7'd0) begin
            bad++; $display("FAIL dup_set_wins got=%b/%b/%b/%0d want=0/1/0/0", we_s, err_underflow, err_overflow, depth);
        end
`else
        total++;
        if (mem_dout_addr0 !== 6'd62 || depth !== 7'd64 || {err_overflow, err_underflow} !== 2'b00) begin
            bad++; $display("FAIL pop_wrap got=%0d/%0d/%b want=62/64/00", mem_dout_addr0, depth, {err_overflow, err_underflow});
        end
        do_op(PUSH, 16'h1234);
        total++;
        if ({we_s, addr_s} !== {1'b1, 6'd63} || depth !== 7'd0) begin bad++; $display("FAIL push_wrap got=%b/%0d/%0d want=1/63/0", we_s, addr_s, depth); end
`endif
    endtask

    task automatic test_reset_swap2();
        apply_reset();
        do_op(PUSH, 16'haaaa);
        do_op(PUSH, 16'hbbbb);
        do_op(SWAP, 16'h0);
        reset = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL swap2_reset_we got=%b want=0", mem_we); end
        @(posedge clk); #1;
        total++;
        if (depth !== 7'd0 || op_ready !== 1'b1) begin bad++; $display("FAIL swap2_reset_state got=%0d/%b want=0/1", depth, op_ready); end
        total++;
        if (ram[0] !== 16'haaaa || ram[1] !== 16'haaaa) begin bad++; $display("FAIL swap2_dropped got=%h/%h want=aaaa/aaaa", ram[0], ram[1]); end
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) ram[i] = 16'h0;
        test_reset();
        test_push();
        test_swap();
        test_binop_dup();
        test_replace_over_nop();
        test_full();
        test_underflow();
        test_reset_swap2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
